stopwatch_ascii_formatter: RTL and testbench

Downstream stage of the stopwatch: on a request pulse, snapshots the stopwatch's minutes/seconds/hundredths values, converts them to decimal digits by iterative subtraction, and streams the ASCII string "MM:SS.hh" (optionally followed by CR LF) one byte at a time. The byte stream uses a valid/ready handshake and feeds the pseudo-terminal UART transmitter. One string is emitted per request.

---
 rtl/stopwatch_ascii_formatter.sv | 200 ++++++++++++++++++++
 tb/tb_stopwatch_ascii_formatter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ascii_formatter.sv
// stopwatch_ascii_formatter
// Snapshots a stopwatch time on a start pulse, converts each field to two
// decimal digits by repeated subtraction of ten, then streams "MM:SS.hh"
// (optionally followed by CR LF) one byte at a time over valid/ready.
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   start              request pulse, honoured only while idle
//   minutes, seconds,  binary time fields; clamped to 99/59/99 on capture
//   hundreth_sec
//   tx_ready           downstream accepts tx_data this cycle
//   tx_data, tx_valid  registered byte stream
//   busy               high whenever a string is in progress
//   done               one-cycle pulse after the last byte is accepted
module stopwatch_ascii_formatter #(
   parameter bit SEND_CRLF = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [9:0] minutes,
   input  logic [9:0] seconds,
   input  logic [9:0] hundreth_sec,
   input  logic       tx_ready,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   output logic       busy,
   output logic       done
);

   localparam int unsigned IN_W      = 10;
   localparam int unsigned VAL_W     = 7;
   localparam int unsigned CNT_W     = 4;
   localparam int unsigned IDX_W     = 4;
   localparam int unsigned NUM_BYTES = SEND_CRLF ? 10 : 8;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state, state_nx;
   logic [VAL_W-1:0] min_q, sec_q, hun_q;
   logic [VAL_W-1:0] min_nx, sec_nx, hun_nx;
   logic [CNT_W-1:0] min_t, sec_t, hun_t;
   logic [CNT_W-1:0] min_t_nx, sec_t_nx, hun_t_nx;
   logic [IDX_W-1:0] idx, idx_nx;
   logic [7:0]       tx_data_nx;
   logic             tx_valid_nx;
   logic             busy_nx;
   logic             done_nx;

   // Saturate a raw input field to its displayable maximum.
   function automatic logic [VAL_W-1:0] clamp(input logic [IN_W-1:0] v,
                                              input logic [VAL_W-1:0] lim);
      return (v > IN_W'(lim)) ? lim : v[VAL_W-1:0];
   endfunction

   // Character at position i of the output string. After conversion the
   // work registers hold the units digits and the counters the tens digits.
   function automatic logic [7:0] ascii_at(input logic [IDX_W-1:0] i,
                                           input logic [CNT_W-1:0] mt,
                                           input logic [VAL_W-1:0] mu,
                                           input logic [CNT_W-1:0] st,
                                           input logic [VAL_W-1:0] su,
                                           input logic [CNT_W-1:0] ht,
                                           input logic [VAL_W-1:0] hu);
      logic [7:0] c;
      c = 8'h00;
      case (i)
         4'd0:    c = 8'h30 + 8'(mt);
         4'd1:    c = 8'h30 + 8'(mu);
         4'd2:    c = 8'h3A;
         4'd3:    c = 8'h30 + 8'(st);
         4'd4:    c = 8'h30 + 8'(su);
         4'd5:    c = 8'h2E;
         4'd6:    c = 8'h30 + 8'(ht);
         4'd7:    c = 8'h30 + 8'(hu);
         4'd8:    c = 8'h0D;
         4'd9:    c = 8'h0A;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   // Next-state and next-register computation.
   always_comb begin
      state_nx    = state;
      min_nx      = min_q;
      sec_nx      = sec_q;
      hun_nx      = hun_q;
      min_t_nx    = min_t;
      sec_t_nx    = sec_t;
      hun_t_nx    = hun_t;
      idx_nx      = idx;
      tx_valid_nx = tx_valid;
      tx_data_nx  = tx_data;
      done_nx     = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               min_nx   = clamp(minutes,      7'd99);
               sec_nx   = clamp(seconds,      7'd59);
               hun_nx   = clamp(hundreth_sec, 7'd99);
               min_t_nx = '0;
               sec_t_nx = '0;
               hun_t_nx = '0;
               idx_nx   = '0;
               state_nx = CONV;
            end
         end

         CONV: begin
            if ((min_q < 7'd10) && (sec_q < 7'd10) && (hun_q < 7'd10)) begin
               idx_nx   = '0;
               state_nx = SEND;
            end else begin
               if (min_q >= 7'd10) begin
                  min_nx   = min_q - 7'd10;
                  min_t_nx = min_t + 4'd1;
               end
               if (sec_q >= 7'd10) begin
                  sec_nx   = sec_q - 7'd10;
                  sec_t_nx = sec_t + 4'd1;
               end
               if (hun_q >= 7'd10) begin
                  hun_nx   = hun_q - 7'd10;
                  hun_t_nx = hun_t + 4'd1;
               end
            end
         end

         SEND: begin
            // First SEND cycle loads the output register; afterwards each
            // accepted byte is immediately replaced by the next one.
            if (!tx_valid) begin
               tx_valid_nx = 1'b1;
               tx_data_nx  = ascii_at(idx, min_t, min_q, sec_t, sec_q,
                                      hun_t, hun_q);
            end else if (tx_ready) begin
               if (idx == LAST_IDX) begin
                  tx_valid_nx = 1'b0;
                  tx_data_nx  = 8'h00;
                  done_nx     = 1'b1;
                  state_nx    = DONE;
               end else begin
                  idx_nx     = idx + 4'd1;
                  tx_data_nx = ascii_at(idx + 4'd1, min_t, min_q, sec_t,
                                        sec_q, hun_t, hun_q);
               end
            end
         end

         DONE: begin
            state_nx = IDLE;
         end

         default: begin
            state_nx = IDLE;
         end
      endcase

      busy_nx = (state_nx != IDLE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         min_q    <= '0;
         sec_q    <= '0;
         hun_q    <= '0;
         min_t    <= '0;
         sec_t    <= '0;
         hun_t    <= '0;
         idx      <= '0;
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         min_q    <= min_nx;
         sec_q    <= sec_nx;
         hun_q    <= hun_nx;
         min_t    <= min_t_nx;
         sec_t    <= sec_t_nx;
         hun_t    <= hun_t_nx;
         idx      <= idx_nx;
         tx_valid <= tx_valid_nx;
         tx_data  <= tx_data_nx;
         busy     <= busy_nx;
         done     <= done_nx;
      end
   end

endmodule

// File: tb/tb_stopwatch_ascii_formatter.sv
// Directed bench for stopwatch_ascii_formatter. Two instances cover both
// SEND_CRLF settings; sel_b picks which one the monitor observes.
module tb_stopwatch_ascii_formatter;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [9:0] minutes, seconds, hundreth_sec;
   logic       tx_ready;
   logic       sel_b;

   logic [7:0] tx_data_a, tx_data_b;
   logic       tx_valid_a, tx_valid_b, busy_a, busy_b, done_a, done_b;

   logic [7:0] tx_data;
   logic       tx_valid, busy, done;

   always #5 clk = ~clk;

   stopwatch_ascii_formatter #(.SEND_CRLF(1'b1)) dut_a (
      .clk(clk), .reset(reset), .start(start), .minutes(minutes),
      .seconds(seconds), .hundreth_sec(hundreth_sec), .tx_ready(tx_ready),
      .tx_data(tx_data_a), .tx_valid(tx_valid_a), .busy(busy_a), .done(done_a));

   stopwatch_ascii_formatter #(.SEND_CRLF(1'b0)) dut_b (
      .clk(clk), .reset(reset), .start(start), .minutes(minutes),
      .seconds(seconds), .hundreth_sec(hundreth_sec), .tx_ready(tx_ready),
      .tx_data(tx_data_b), .tx_valid(tx_valid_b), .busy(busy_b), .done(done_b));

   assign tx_data  = sel_b ? tx_data_b  : tx_data_a;
   assign tx_valid = sel_b ? tx_valid_b : tx_valid_a;
   assign busy     = sel_b ? busy_b     : busy_a;
   assign done     = sel_b ? done_b     : done_a;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor state, sampled mid-cycle (2 time units after the falling edge).
   int         cyc = 0;
   logic [7:0] cap [16];
   int         xfers, first_xfer_cyc, last_xfer_cyc;
   int         accept_cyc, first_valid_cyc, done_cnt, done_cyc;
   bit         accept_seen, valid_seen, prev_stall, prev_done;
   logic       busy_after_done;
   logic [7:0] prev_data;

   always begin
      @(negedge clk);
      #2;
      cyc++;
      if (!reset) begin
         if (prev_stall) begin
            check("hold_valid", 32'(tx_valid), 32'd1);
            check("hold_data", 32'(tx_data), 32'(prev_data));
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         if (!accept_seen && start && !busy) begin
            accept_seen = 1'b1;
            accept_cyc  = cyc;
         end
         if (accept_seen && !valid_seen && tx_valid) begin
            valid_seen      = 1'b1;
            first_valid_cyc = cyc;
         end
         if (tx_valid && tx_ready) begin
            if (xfers < 16) cap[xfers] = tx_data;
            if (xfers == 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
            xfers++;
         end
         if (prev_done) busy_after_done = busy;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_done = done;
      end else begin
         prev_stall = 1'b0;
         prev_done  = 1'b0;
      end
   end

   task automatic clear_mon();
      xfers           = 0;
      done_cnt        = 0;
      accept_seen     = 1'b0;
      valid_seen      = 1'b0;
      first_valid_cyc = -1;
      accept_cyc      = 0;
      done_cyc        = -1;
      first_xfer_cyc  = -1;
      last_xfer_cyc   = -100;
      busy_after_done = 1'b1;
   endtask

   // One complete request: expected string is the 8-char time, CR LF added
   // by the bench for n=10. t is the largest tens digit of the clamped input.
   task automatic run(input string tag, input logic [9:0] m, input logic [9:0] s,
                      input logic [9:0] h, input int t, input bit toggle,
                      input bit poke, input string exp, input int n);
      int         k;
      bit         poked;
      logic [7:0] e;
      clear_mon();
      @(negedge clk);
      minutes = m; seconds = s; hundreth_sec = h;
      start = 1'b1; tx_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1 check({tag, "_busy_rise"}, 32'(busy), 32'd1);
      k = 0;
      poked = 1'b0;
      while (done_cnt == 0 && k < 300) begin
         @(negedge clk);
         k++;
         start = 1'b0;
         if (toggle) tx_ready = ~tx_ready;
         if (poke && !poked && xfers >= 3) begin
            poked = 1'b1;
            start = 1'b1;
            minutes = 10'd99; seconds = 10'd99; hundreth_sec = 10'd99;
         end
      end
      check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #3;
      tx_ready = 1'b1;
      check({tag, "_xfers"}, 32'(xfers), 32'(n));
      for (int i = 0; i < n && i < 16; i++) begin
         if (i < 8)       e = exp.getc(i);
         else if (i == 8) e = 8'h0D;
         else             e = 8'h0A;
         check($sformatf("%s_byte%0d", tag, i), 32'(cap[i]), 32'(e));
      end
      check({tag, "_conv_lat"}, 32'(first_valid_cyc - accept_cyc), 32'(t + 3));
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, "_done_pos"}, 32'(done_cyc - last_xfer_cyc), 32'd1);
      check({tag, "_busy_fall"}, 32'(busy_after_done), 32'd0);
      check({tag, "_idle_valid"}, 32'(tx_valid), 32'd0);
      if (!toggle)
         check({tag, "_burst"}, 32'(last_xfer_cyc - first_xfer_cyc), 32'(n - 1));
   endtask

   initial begin
      int k;
      reset = 1'b1; start = 1'b0; tx_ready = 1'b0; sel_b = 1'b0;
      minutes = '0; seconds = '0; hundreth_sec = '0;
      clear_mon();
      prev_stall = 1'b0; prev_done = 1'b0; prev_data = 8'h00;
      repeat (2) @(negedge clk);
      #1;
      check("rst_valid", 32'(tx_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_data", 32'(tx_data), 32'h00);
      @(negedge clk);
      reset = 1'b0;

      run("basic",   10'd1,   10'd23, 10'd45,  4, 1'b0, 1'b0, "01:23.45", 10);
      run("clamp",   10'd150, 10'd75, 10'd200, 9, 1'b0, 1'b0, "99:59.99", 10);
      run("zero_bp", 10'd0,   10'd0,  10'd0,   0, 1'b1, 1'b0, "00:00.00", 10);
      run("restart", 10'd30,  10'd40, 10'd50,  5, 1'b0, 1'b1, "30:40.50", 10);

      // Abort mid-stream with asynchronous reset after the 4th transfer.
      clear_mon();
      @(negedge clk);
      minutes = 10'd1; seconds = 10'd23; hundreth_sec = 10'd45;
      start = 1'b1; tx_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (xfers < 4 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("abort_reached", 32'(xfers), 32'd4);
      check("abort_pre_valid", 32'(tx_valid), 32'd1);
      reset = 1'b1;
      #1;
      check("abort_valid", 32'(tx_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_data", 32'(tx_data), 32'h00);
      check("abort_done", 32'(done), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run("fresh",   10'd12,  10'd34, 10'd56,  5, 1'b0, 1'b0, "12:34.56", 10);

      repeat (4) @(negedge clk);
      sel_b = 1'b1;
      run("nocrlf",  10'd59,  10'd59, 10'd99,  9, 1'b0, 1'b0, "59:59.99", 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
